// File: rtl/pwm_capture_pkg.sv
// Shared types and helpers for the multi-channel PWM capture block.
// Per-channel FSM states and the bus-packing offset helper live here.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } chan_state_e;

  // LSB of channel ch inside a bus packed as CHANNELS slices of width bits.
  function automatic int chan_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/pwm_capture_chan.sv
// One PWM measurement channel: synchroniser, edge detect, counters, FSM, range compare.
// Range compare is built only when PWM_CAPTURE_RANGE_CHECK_EN is defined.
module pwm_capture_chan
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             pwm_i,
  input  logic [CNT_W-1:0] lim_lo_i,
  input  logic [CNT_W-1:0] lim_hi_i,
  output logic [CNT_W-1:0] high_time_o,
  output logic [CNT_W-1:0] period_o,
  output logic             valid_o,
  output logic             stuck_o,
  output logic             stuck_level_o,
  output logic             range_err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic [CNT_W-1:0] hi_q;
  chan_state_e      state_q;
  logic [CNT_W-1:0] high_time_q, period_q;
  logic             valid_q, stuck_q, stuck_level_q, range_err_q;

  logic rise, fall, timeout, range_bad;

  // cnt measures from the last rise (period/high time); idle from any edge (stuck timeout).
  always_comb begin
    rise    = sync2_q & ~prev_q;
    fall    = ~sync2_q & prev_q;
    cnt_d   = rise ? CNT_ONE : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE);
    idle_d  = (rise || fall) ? CNT_ONE : ((idle_q == CNT_MAX) ? idle_q : idle_q + CNT_ONE);
    timeout = !stuck_q && (idle_q >= TIMEOUT_C);
  end

`ifdef PWM_CAPTURE_RANGE_CHECK_EN
  assign range_bad = (hi_q < lim_lo_i) || (hi_q > lim_hi_i);
`else
  logic unused_lim;
  assign range_bad  = 1'b0;
  assign unused_lim = ^{lim_lo_i, lim_hi_i};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      prev_q        <= 1'b0;
      cnt_q         <= '0;
      idle_q        <= '0;
      hi_q          <= '0;
      state_q       <= WAIT_RISE;
      high_time_q   <= '0;
      period_q      <= '0;
      valid_q       <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
      range_err_q   <= 1'b0;
    end else begin
      sync1_q <= pwm_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      valid_q <= 1'b0;
      if (!en_i) begin
        state_q       <= WAIT_RISE;
        stuck_q       <= 1'b0;
        stuck_level_q <= 1'b0;
        range_err_q   <= 1'b0;
      end else if (rise || fall) begin
        // A stuck channel is always in WAIT_RISE, so the clearing edge at most arms it.
        stuck_q       <= 1'b0;
        stuck_level_q <= 1'b0;
        case (state_q)
          WAIT_RISE: if (rise) state_q <= HIGH;
          HIGH: begin
            if (fall) begin
              hi_q    <= cnt_q;
              state_q <= LOW;
            end
          end
          LOW: begin
            if (rise) begin
              high_time_q <= hi_q;
              period_q    <= cnt_q;
              valid_q     <= 1'b1;
              range_err_q <= range_bad;
              state_q     <= HIGH;
            end
          end
          default: state_q <= WAIT_RISE;
        endcase
      end else if (timeout) begin
        stuck_q       <= 1'b1;
        stuck_level_q <= sync2_q;
        state_q       <= WAIT_RISE;
      end
    end
  end

  assign high_time_o   = high_time_q;
  assign period_o      = period_q;
  assign valid_o       = valid_q;
  assign stuck_o       = stuck_q;
  assign stuck_level_o = stuck_level_q;
  assign range_err_o   = range_err_q;

endmodule

// File: rtl/pwm_capture_mc.sv
// Multi-channel PWM capture: CHANNELS independent pwm_capture_chan instances, buses packed per channel.
// Optional high-time range check enabled by defining PWM_CAPTURE_RANGE_CHECK_EN.
module pwm_capture_mc
  import pwm_capture_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 50000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       pwm_in,
  output logic [CHANNELS*CNT_W-1:0] high_time,
  output logic [CHANNELS*CNT_W-1:0] period,
  output logic [CHANNELS-1:0]       valid,
  output logic [CHANNELS-1:0]       stuck,
  output logic [CHANNELS-1:0]       stuck_level,
  input  logic [CNT_W-1:0]          lim_lo,
  input  logic [CNT_W-1:0]          lim_hi,
  output logic [CHANNELS-1:0]       range_err
);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      localparam int LSB = chan_lsb(gi, CNT_W);
      pwm_capture_chan #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
      ) u_chan (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en[gi]),
        .pwm_i        (pwm_in[gi]),
        .lim_lo_i     (lim_lo),
        .lim_hi_i     (lim_hi),
        .high_time_o  (high_time[LSB +: CNT_W]),
        .period_o     (period[LSB +: CNT_W]),
        .valid_o      (valid[gi]),
        .stuck_o      (stuck[gi]),
        .stuck_level_o(stuck_level[gi]),
        .range_err_o  (range_err[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pwm_capture_mc.sv
// Self-checking bench for pwm_capture_mc: scenario tasks plus randomized waveforms,
// with expectations derived from the waveform parameters (high, low, number of periods).
module tb_pwm_capture_mc;
  localparam int CH = 4;
  localparam int W = 16;
  localparam int TO = 100;
  localparam int EVMAX = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [CH-1:0]   en;
  logic            pin[CH];
  logic [CH-1:0]   pwm_in;
  logic [W-1:0]    lim_lo, lim_hi;
  logic [CH*W-1:0] high_time, period;
  logic [CH-1:0]   valid, stuck, stuck_level, range_err;

  assign pwm_in = {pin[3], pin[2], pin[1], pin[0]};

  pwm_capture_mc #(.CHANNELS(CH), .CNT_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .pwm_in(pwm_in),
    .high_time(high_time), .period(period), .valid(valid),
    .stuck(stuck), .stuck_level(stuck_level),
    .lim_lo(lim_lo), .lim_hi(lim_hi), .range_err(range_err)
  );

  int errors = 0;
  int checks = 0;

  // Event log of every valid strobe, per channel.
  int ev_cnt[CH];
  int ev_ht[CH][EVMAX];
  int ev_per[CH][EVMAX];
  bit ev_rerr[CH][EVMAX];
  int ev_cyc[CH][EVMAX];
  int cyc;

  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (valid[c] === 1'b1) begin
        if (ev_cnt[c] < EVMAX) begin
          ev_ht[c][ev_cnt[c]]   = int'(high_time[c*W +: W]);
          ev_per[c][ev_cnt[c]]  = int'(period[c*W +: W]);
          ev_rerr[c][ev_cnt[c]] = range_err[c];
          ev_cyc[c][ev_cnt[c]]  = cyc;
        end
        ev_cnt[c] = ev_cnt[c] + 1;
      end
    end
    cyc = cyc + 1;
  end

  function automatic bit exp_rerr(input int h, input int lo, input int hi);
`ifdef PWM_CAPTURE_RANGE_CHECK_EN
    return (h < lo) || (h > hi);
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive_wave(input int ch, input int h, input int l, input int n);
    for (int k = 0; k < n; k++) begin
      pin[ch] = 1'b1;
      repeat (h) @(negedge clk);
      pin[ch] = 1'b0;
      repeat (l) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = '1;
    for (int c = 0; c < CH; c++) pin[c] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = '1;
    lim_lo = 16'd4;
    lim_hi = 16'd8;
    for (int c = 0; c < CH; c++) pin[c] = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (high_time !== '0) begin errors++; $display("FAIL reset_high_time got %h expected 0", high_time); end
    checks++; if (period !== '0) begin errors++; $display("FAIL reset_period got %h expected 0", period); end
    checks++; if (valid !== '0) begin errors++; $display("FAIL reset_valid got %b expected 0", valid); end
    checks++; if (stuck !== '0) begin errors++; $display("FAIL reset_stuck got %b expected 0", stuck); end
    checks++; if (stuck_level !== '0) begin errors++; $display("FAIL reset_stuck_level got %b expected 0", stuck_level); end
    checks++; if (range_err !== '0) begin errors++; $display("FAIL reset_range_err got %b expected 0", range_err); end
    rst = 1'b0;
    $display("reset: outputs checked during reset");
  endtask

  task automatic test_basic();
    int base, n;
    do_reset();
    base = ev_cnt[0];
    drive_wave(0, 3, 7, 5);
    repeat (8) @(negedge clk);
    n = ev_cnt[0] - base;
    checks++; if (n !== 4) begin errors++; $display("FAIL basic_count got %0d expected 4", n); end
    for (int i = 0; i < n && i < 4; i++) begin
      checks++; if (ev_ht[0][base+i] !== 3) begin errors++; $display("FAIL basic_ht ev%0d got %0d expected 3", i, ev_ht[0][base+i]); end
      checks++; if (ev_per[0][base+i] !== 10) begin errors++; $display("FAIL basic_per ev%0d got %0d expected 10", i, ev_per[0][base+i]); end
      if (i > 0) begin
        checks++;
        if (ev_cyc[0][base+i] - ev_cyc[0][base+i-1] !== 10) begin
          errors++; $display("FAIL basic_spacing ev%0d got %0d expected 10", i, ev_cyc[0][base+i] - ev_cyc[0][base+i-1]);
        end
      end
    end
    $display("basic: ch0 3/7 x5 -> %0d valids", n);
  endtask

  task automatic test_stuck();
    int base, n;
    do_reset();
    base = ev_cnt[1];
    pin[1] = 1'b1;
    // Rise is detected 3 clocks after the pin moves; stuck follows TIMEOUT clocks later.
    repeat (TO + 2) @(negedge clk);
    checks++; if (stuck[1] !== 1'b0) begin errors++; $display("FAIL stuck_early got %b expected 0", stuck[1]); end
    @(negedge clk);
    checks++; if (stuck[1] !== 1'b1) begin errors++; $display("FAIL stuck_set got %b expected 1", stuck[1]); end
    checks++; if (stuck_level[1] !== 1'b1) begin errors++; $display("FAIL stuck_level got %b expected 1", stuck_level[1]); end
    repeat (150 - (TO + 3)) @(negedge clk);
    pin[1] = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (stuck[1] !== 1'b1) begin errors++; $display("FAIL stuck_hold got %b expected 1", stuck[1]); end
    @(negedge clk);
    checks++; if (stuck[1] !== 1'b0) begin errors++; $display("FAIL stuck_clear got %b expected 0", stuck[1]); end
    n = ev_cnt[1] - base;
    checks++; if (n !== 0) begin errors++; $display("FAIL stuck_no_valid got %0d expected 0", n); end
    drive_wave(1, 4, 6, 3);
    repeat (8) @(negedge clk);
    n = ev_cnt[1] - base;
    checks++; if (n !== 2) begin errors++; $display("FAIL stuck_recover_count got %0d expected 2", n); end
    for (int i = 0; i < n && i < 2; i++) begin
      checks++; if (ev_ht[1][base+i] !== 4) begin errors++; $display("FAIL stuck_recover_ht got %0d expected 4", ev_ht[1][base+i]); end
      checks++; if (ev_per[1][base+i] !== 10) begin errors++; $display("FAIL stuck_recover_per got %0d expected 10", ev_per[1][base+i]); end
    end
    $display("stuck: ch1 held high 150 cycles, then %0d valids", n);
  endtask

  task automatic test_enable();
    int base, n;
    do_reset();
    base = ev_cnt[2];
    drive_wave(2, 5, 15, 3);
    pin[2] = 1'b1;
    repeat (4) @(negedge clk);
    en[2] = 1'b0;
    @(negedge clk);
    pin[2] = 1'b0;
    repeat (15) @(negedge clk);
    drive_wave(2, 5, 15, 2);
    n = ev_cnt[2] - base;
    checks++; if (n !== 3) begin errors++; $display("FAIL en_before_count got %0d expected 3", n); end
    checks++; if (high_time[2*W +: W] !== 16'd5) begin errors++; $display("FAIL en_hold_ht got %0d expected 5", high_time[2*W +: W]); end
    checks++; if (period[2*W +: W] !== 16'd20) begin errors++; $display("FAIL en_hold_per got %0d expected 20", period[2*W +: W]); end
    checks++; if (stuck[2] !== 1'b0) begin errors++; $display("FAIL en_stuck got %b expected 0", stuck[2]); end
    en[2] = 1'b1;
    repeat (10) @(negedge clk);
    base = ev_cnt[2];
    drive_wave(2, 5, 15, 3);
    repeat (8) @(negedge clk);
    n = ev_cnt[2] - base;
    checks++; if (n !== 2) begin errors++; $display("FAIL en_after_count got %0d expected 2", n); end
    for (int i = 0; i < n && i < 2; i++) begin
      checks++; if (ev_ht[2][base+i] !== 5) begin errors++; $display("FAIL en_after_ht got %0d expected 5", ev_ht[2][base+i]); end
      checks++; if (ev_per[2][base+i] !== 20) begin errors++; $display("FAIL en_after_per got %0d expected 20", ev_per[2][base+i]); end
    end
    $display("enable: ch2 5/20, en toggled, %0d valids after re-enable", n);
  endtask

  task automatic test_reset_mid();
    int base[CH];
    do_reset();
    fork
      drive_wave(0, 4, 6, 3);
      drive_wave(1, 4, 6, 3);
      drive_wave(2, 4, 6, 3);
      drive_wave(3, 4, 6, 3);
    join
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (high_time !== '0) begin errors++; $display("FAIL rstmid_high_time got %h expected 0", high_time); end
    checks++; if (period !== '0) begin errors++; $display("FAIL rstmid_period got %h expected 0", period); end
    checks++; if ({valid, stuck, stuck_level, range_err} !== '0) begin
      errors++; $display("FAIL rstmid_flags got %b expected 0", {valid, stuck, stuck_level, range_err});
    end
    rst = 1'b0;
    for (int c = 0; c < CH; c++) base[c] = ev_cnt[c];
    fork
      drive_wave(0, 4, 6, 1);
      drive_wave(1, 4, 6, 1);
      drive_wave(2, 4, 6, 1);
      drive_wave(3, 4, 6, 1);
    join
    repeat (8) @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      checks++; if (ev_cnt[c] - base[c] !== 0) begin errors++; $display("FAIL rstmid_spurious ch%0d got %0d expected 0", c, ev_cnt[c] - base[c]); end
    end
    $display("reset_mid: reset in LOW on all channels, no spurious valid");
  endtask

  task automatic test_range();
    int hs[5];
    int base, n;
    bit want;
    hs[0] = 5; hs[1] = 3; hs[2] = 6; hs[3] = 9; hs[4] = 2;
    do_reset();
    lim_lo = 16'd4;
    lim_hi = 16'd8;
    base = ev_cnt[3];
    for (int k = 0; k < 5; k++) begin
      pin[3] = 1'b1;
      repeat (hs[k]) @(negedge clk);
      pin[3] = 1'b0;
      repeat (7) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    n = ev_cnt[3] - base;
    checks++; if (n !== 4) begin errors++; $display("FAIL range_count got %0d expected 4", n); end
    for (int i = 0; i < n && i < 4; i++) begin
      want = exp_rerr(hs[i], 4, 8);
      checks++; if (ev_ht[3][base+i] !== hs[i]) begin errors++; $display("FAIL range_ht ev%0d got %0d expected %0d", i, ev_ht[3][base+i], hs[i]); end
      checks++; if (ev_per[3][base+i] !== hs[i] + 7) begin errors++; $display("FAIL range_per ev%0d got %0d expected %0d", i, ev_per[3][base+i], hs[i] + 7); end
      checks++; if (ev_rerr[3][base+i] !== want) begin errors++; $display("FAIL range_err ev%0d got %b expected %b", i, ev_rerr[3][base+i], want); end
    end
    want = exp_rerr(9, 4, 8);
    checks++; if (range_err[3] !== want) begin errors++; $display("FAIL range_hold got %b expected %b", range_err[3], want); end
    $display("range: ch3 highs 5,3,6,9 with limits 4..8 -> %0d valids", n);
  endtask

  task automatic test_multi();
    int hs[CH], ls[CH], base[CH];
    int n;
    hs[0] = 3; ls[0] = 4;
    hs[1] = 5; ls[1] = 6;
    hs[2] = 6; ls[2] = 7;
    hs[3] = 8; ls[3] = 9;
    do_reset();
    for (int c = 0; c < CH; c++) base[c] = ev_cnt[c];
    fork
      drive_wave(0, hs[0], ls[0], 4);
      drive_wave(1, hs[1], ls[1], 4);
      drive_wave(2, hs[2], ls[2], 4);
      drive_wave(3, hs[3], ls[3], 4);
    join
    repeat (8) @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      n = ev_cnt[c] - base[c];
      checks++; if (n !== 3) begin errors++; $display("FAIL multi_count ch%0d got %0d expected 3", c, n); end
      for (int i = 0; i < n && i < 3; i++) begin
        checks++; if (ev_ht[c][base[c]+i] !== hs[c]) begin errors++; $display("FAIL multi_ht ch%0d got %0d expected %0d", c, ev_ht[c][base[c]+i], hs[c]); end
        checks++; if (ev_per[c][base[c]+i] !== hs[c] + ls[c]) begin errors++; $display("FAIL multi_per ch%0d got %0d expected %0d", c, ev_per[c][base[c]+i], hs[c] + ls[c]); end
      end
    end
    $display("multi: periods 7/11/13/17 measured concurrently");
  endtask

  task automatic test_random();
    int hs[CH], ls[CH], ns[CH], base[CH];
    int n, lo, hi;
    bit want;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      lo = int'($urandom_range(20, 0));
      hi = lo + int'($urandom_range(20, 0));
      lim_lo = W'(lo);
      lim_hi = W'(hi);
      for (int c = 0; c < CH; c++) begin
        hs[c] = int'($urandom_range(40, 1));
        ls[c] = int'($urandom_range(40, 1));
        ns[c] = int'($urandom_range(5, 3));
        base[c] = ev_cnt[c];
      end
      fork
        drive_wave(0, hs[0], ls[0], ns[0]);
        drive_wave(1, hs[1], ls[1], ns[1]);
        drive_wave(2, hs[2], ls[2], ns[2]);
        drive_wave(3, hs[3], ls[3], ns[3]);
      join
      repeat (8) @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        n = ev_cnt[c] - base[c];
        want = exp_rerr(hs[c], lo, hi);
        checks++; if (n !== ns[c] - 1) begin errors++; $display("FAIL rand_count r%0d ch%0d got %0d expected %0d", r, c, n, ns[c] - 1); end
        for (int i = 0; i < n && i < ns[c] - 1; i++) begin
          checks++; if (ev_ht[c][base[c]+i] !== hs[c]) begin errors++; $display("FAIL rand_ht r%0d ch%0d got %0d expected %0d", r, c, ev_ht[c][base[c]+i], hs[c]); end
          checks++; if (ev_per[c][base[c]+i] !== hs[c] + ls[c]) begin errors++; $display("FAIL rand_per r%0d ch%0d got %0d expected %0d", r, c, ev_per[c][base[c]+i], hs[c] + ls[c]); end
          checks++; if (ev_rerr[c][base[c]+i] !== want) begin errors++; $display("FAIL rand_rerr r%0d ch%0d got %b expected %b", r, c, ev_rerr[c][base[c]+i], want); end
        end
        $display("random r%0d ch%0d: high=%0d low=%0d periods=%0d valids=%0d", r, c, hs[c], ls[c], ns[c], n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuck();
    test_enable();
    test_reset_mid();
    test_range();
    test_multi();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
